// File: rtl/data_mem_arbiter_if.sv
// Requester-side bundle for the data memory arbiter: one request channel
// (valid/ready with write flag, byte address and write data) plus the
// registered response (one-cycle valid pulse and read data).
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  // The requester (CPU or DMA/debug port) drives the request fields
  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  // The arbiter accepts requests and returns responses
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the 1Kx32 data memory.
// Requester 0 is the CPU load/store port, requester 1 the DMA/debug port.
// One transaction is accepted in IDLE, driven onto the memory for exactly one
// ACCESS cycle, and answered with a registered response pulse in the cycle after.
module data_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  data_mem_arbiter_if.slave  r0,
  data_mem_arbiter_if.slave  r1,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [DATA_W-1:0]  mem_write_data,
  output logic               mem_write,
  output logic               mem_read,
  input  logic [DATA_W-1:0]  mem_read_data,
  output logic               busy
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state;
  state_t            state_next;
  logic              last_gnt;
  logic              owner;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              grant0;
  logic              grant1;
  logic              rsp_valid0;
  logic              rsp_valid1;
  logic [DATA_W-1:0] rsp_rdata0;
  logic [DATA_W-1:0] rsp_rdata1;

  // State register; reset returns to IDLE so the memory strobes drop at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Arbitration in IDLE (ties go to the requester that was not granted last)
  // and memory strobes driven from the latched transaction in ACCESS
  always_comb begin
    state_next     = state;
    grant0         = 1'b0;
    grant1         = 1'b0;
    busy           = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && r0.req_valid && (!r1.req_valid || last_gnt)) begin
          grant0 = 1'b1;
        end else if (rst_n && r1.req_valid) begin
          grant1 = 1'b1;
        end
        if (grant0 || grant1) begin
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        state_next     = IDLE;
        busy           = 1'b1;
        mem_address    = lat_addr;
        mem_write      = lat_write;
        mem_read       = !lat_write;
        mem_write_data = lat_write ? lat_wdata : '0;
      end
      default: state_next = IDLE;
    endcase
  end

  assign r0.req_ready = grant0;
  assign r1.req_ready = grant1;
  assign r0.rsp_valid = rsp_valid0;
  assign r1.rsp_valid = rsp_valid1;
  assign r0.rsp_rdata = rsp_rdata0;
  assign r1.rsp_rdata = rsp_rdata1;

  // Latch the winning request on accept and return the owner's response at the end of ACCESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt   <= 1'b1;
      owner      <= 1'b0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      rsp_rdata0 <= '0;
      rsp_rdata1 <= '0;
    end else begin
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      if (state == IDLE && (grant0 || grant1)) begin
        owner     <= grant1;
        last_gnt  <= grant1;
        lat_write <= grant1 ? r1.req_write : r0.req_write;
        lat_addr  <= grant1 ? r1.req_addr  : r0.req_addr;
        lat_wdata <= grant1 ? r1.req_wdata : r0.req_wdata;
      end
      if (state == ACCESS) begin
        if (owner) begin
          rsp_valid1 <= 1'b1;
          rsp_rdata1 <= lat_write ? '0 : mem_read_data;
        end else begin
          rsp_valid0 <= 1'b1;
          rsp_rdata0 <= lat_write ? '0 : mem_read_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic from both requesters compared every
// cycle against a transaction-level reference model with its own memory copy.
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;
  logic        busy;

  data_mem_arbiter_if r0_if ();
  data_mem_arbiter_if r1_if ();

  data_mem_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .r0             (r0_if),
    .r1             (r1_if),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data),
    .busy           (busy)
  );

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  // Data memory: synchronous write, read gated by mem_read
  logic [31:0] mem [1024];
  assign mem_read_data = mem_read ? mem[mem_address[11:2]] : 32'h0;

  // Memory write port
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[11:2]] = mem_write_data;
  end

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one in-flight transaction at most, round-robin memory of last grant
  bit          m_busy;
  int          m_own;
  bit          m_wr;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  int          m_last;
  bit          m_rv [2];
  logic [31:0] m_rd [2];
  bit          m_acc [2];
  logic [31:0] shadow [1024];
  int          m_win;

  function automatic bit req_valid(input int r);
    return (r == 0) ? r0_if.req_valid : r1_if.req_valid;
  endfunction

  function automatic int winner();
    bit v0 = r0_if.req_valid;
    bit v1 = r1_if.req_valid;
    if (!rst_n || m_busy) return -1;
    if (v0 && v1) return 1 - m_last;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask

  task automatic set_req(input int r, input bit v, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (r == 0) begin
      r0_if.req_valid = v; r0_if.req_write = w; r0_if.req_addr = a; r0_if.req_wdata = d;
    end else begin
      r1_if.req_valid = v; r1_if.req_write = w; r1_if.req_addr = a; r1_if.req_wdata = d;
    end
  endtask

  // Model update at each edge: finish the in-flight access or accept a new winner
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_last = 1;
      m_own  = 0;
      for (int i = 0; i < 2; i++) begin
        m_rv[i] = 1'b0; m_rd[i] = 32'h0; m_acc[i] = 1'b0;
      end
    end else begin
      m_win = winner();
      m_acc[0] = 1'b0; m_acc[1] = 1'b0;
      m_rv[0]  = 1'b0; m_rv[1]  = 1'b0;
      if (m_busy) begin
        if (m_wr) begin
          m_rd[m_own] = 32'h0;
          shadow[m_addr[11:2]] = m_wdata;
        end else begin
          m_rd[m_own] = shadow[m_addr[11:2]];
        end
        m_rv[m_own] = 1'b1;
        m_busy = 1'b0;
      end else if (m_win >= 0) begin
        m_acc[m_win] = 1'b1;
        m_own   = m_win;
        m_last  = m_win;
        m_busy  = 1'b1;
        m_wr    = (m_win == 0) ? r0_if.req_write : r1_if.req_write;
        m_addr  = (m_win == 0) ? r0_if.req_addr  : r1_if.req_addr;
        m_wdata = (m_win == 0) ? r0_if.req_wdata : r1_if.req_wdata;
      end
    end
  end

  // Every-cycle comparison of all DUT outputs against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      int w;
      w = winner();
      check_output("r0_ready", {31'h0, r0_if.req_ready}, {31'h0, w == 0});
      check_output("r1_ready", {31'h0, r1_if.req_ready}, {31'h0, w == 1});
      check_output("busy", {31'h0, busy}, {31'h0, m_busy});
      check_output("mem_write", {31'h0, mem_write}, {31'h0, m_busy && m_wr});
      check_output("mem_read", {31'h0, mem_read}, {31'h0, m_busy && !m_wr});
      check_output("mem_address", mem_address, m_busy ? m_addr : 32'h0);
      check_output("mem_write_data", mem_write_data, (m_busy && m_wr) ? m_wdata : 32'h0);
      check_output("r0_rsp_valid", {31'h0, r0_if.rsp_valid}, {31'h0, m_rv[0]});
      check_output("r1_rsp_valid", {31'h0, r1_if.rsp_valid}, {31'h0, m_rv[1]});
      check_output("r0_rsp_rdata", r0_if.rsp_rdata, m_rd[0]);
      check_output("r1_rsp_rdata", r1_if.rsp_rdata, m_rd[1]);
    end
  end

  // Issue one request and hold it until the DUT accepts it; returns just after the accept edge
  task automatic apply_stimulus(input int r, input bit w, input logic [31:0] a, input logic [31:0] d);
    bit ok = 1'b0;
    @(posedge clk); #1;
    set_req(r, 1'b1, w, a, d);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if ((r == 0) ? r0_if.req_ready : r1_if.req_ready) begin
        @(posedge clk); #1;
        set_req(r, 1'b0, 1'b0, 32'h0, 32'h0);
        ok = 1'b1;
      end
    end
    if (!ok) begin
      check_output("accept_timeout", 32'h0, 32'h1);
      set_req(r, 1'b0, 1'b0, 32'h0, 32'h0);
    end
  endtask

  initial begin
    int grants [$];
    int gcyc [$];
    logic [31:0] d0;
    logic [31:0] d1;

    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'h0; shadow[i] = 32'h0;
    end
    mem[0] = 32'h30E; shadow[0] = 32'h30E;
    mem[1] = 32'h50;  shadow[1] = 32'h50;
    mem[2] = 32'h369; shadow[2] = 32'h369;
    mem[8] = 32'h31B; shadow[8] = 32'h31B;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    cmp_on = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_busy", {31'h0, busy}, 32'h0);
    check_output("reset_rsp", {30'h0, r1_if.rsp_valid, r0_if.rsp_valid}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Write then read back through requester 0
    apply_stimulus(0, 1'b1, 32'h10, 32'hCAFE);
    @(negedge clk);
    check_output("t1_mem_write", {31'h0, mem_write}, 32'h1);
    check_output("t1_mem_address", mem_address, 32'h10);
    @(negedge clk);
    check_output("t1_rsp_valid", {31'h0, r0_if.rsp_valid}, 32'h1);
    check_output("t1_rsp_rdata", r0_if.rsp_rdata, 32'h0);
    apply_stimulus(0, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check_output("t1_mem_read", {31'h0, mem_read}, 32'h1);
    @(negedge clk);
    check_output("t1_read_rdata", r0_if.rsp_rdata, 32'hCAFE);

    // Requester 1 read of preloaded word 1
    apply_stimulus(1, 1'b0, 32'h4, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check_output("t2_r1_rsp_valid", {31'h0, r1_if.rsp_valid}, 32'h1);
    check_output("t2_r1_rdata", r1_if.rsp_rdata, 32'h50);
    check_output("t2_r0_rsp_valid", {31'h0, r0_if.rsp_valid}, 32'h0);

    // Both requesters held from reset: grants must alternate starting with R0
    @(negedge clk); #2;
    rst_n = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h8, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    d0 = 32'h0; d1 = 32'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (r0_if.req_ready) begin grants.push_back(0); gcyc.push_back(k); end
      if (r1_if.req_ready) begin grants.push_back(1); gcyc.push_back(k); end
      if (r0_if.rsp_valid) d0 = r0_if.rsp_rdata;
      if (r1_if.rsp_valid) d1 = r1_if.rsp_rdata;
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    check_output("t3_grant_count", grants.size(), 32'd4);
    for (int k = 0; k < grants.size() && k < 4; k++) begin
      check_output("t3_grant_owner", grants[k], k % 2);
      check_output("t3_grant_cycle", gcyc[k], 2 * k);
    end
    check_output("t3_r0_rdata", d0, 32'h30E);
    check_output("t3_r1_rdata", d1, 32'h369);
    repeat (2) @(posedge clk);

    // R0 request arriving in the cycle R1's response pulses
    apply_stimulus(1, 1'b0, 32'h4, 32'h0);
    @(negedge clk);
    check_output("t4_busy_0", {31'h0, busy}, 32'h1);
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b0, 32'h8, 32'h0);
    @(negedge clk);
    check_output("t4_busy_1", {31'h0, busy}, 32'h0);
    check_output("t4_r1_rsp_valid", {31'h0, r1_if.rsp_valid}, 32'h1);
    check_output("t4_r0_ready", {31'h0, r0_if.req_ready}, 32'h1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check_output("t4_busy_2", {31'h0, busy}, 32'h1);
    @(negedge clk);
    check_output("t4_busy_3", {31'h0, busy}, 32'h0);
    check_output("t4_r0_rdata", r0_if.rsp_rdata, 32'h369);

    // Reset during a write access aborts it
    apply_stimulus(0, 1'b1, 32'h20, 32'hDEAD);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_output("t5_mem_write_drop", {31'h0, mem_write}, 32'h0);
    check_output("t5_busy_drop", {31'h0, busy}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check_output("t5_word8", mem[8], 32'h31B);
    check_output("t5_rsp_valid", {30'h0, r1_if.rsp_valid, r0_if.rsp_valid}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h8, 32'h0);
    @(negedge clk);
    check_output("t5_first_tie", {30'h0, r1_if.req_ready, r0_if.req_ready}, 32'h1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);

    // Idle with no requests keeps the memory bus quiet
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_output("t6_mem_read", {31'h0, mem_read}, 32'h0);
      check_output("t6_mem_write", {31'h0, mem_write}, 32'h0);
      check_output("t6_mem_address", mem_address, 32'h0);
      check_output("t6_busy", {31'h0, busy}, 32'h0);
    end

    // Randomized traffic from both requesters, one mid-run reset
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1500) begin
        @(negedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      for (int r = 0; r < 2; r++) begin
        if (!req_valid(r) || m_acc[r]) begin
          if ($urandom_range(0, 99) < 60)
            set_req(r, 1'b1, $urandom_range(0, 1) == 1, $urandom() & 32'hFFFF_F03F, $urandom());
          else
            set_req(r, 1'b0, 1'b0, 32'h0, 32'h0);
        end
      end
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    cmp_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
